mips_prog_loader: RTL and testbench

Writer-side companion to the pipeline: streams a program image into the pipeline's instruction memory before execution starts. Consumes a byte stream with a valid/ready handshake, assembles big-endian 32-bit instruction words and issues one-cycle IMEM write strobes. Holds the pipeline (cpu_hold) until the image is fully loaded and its checksum is verified. It sits between the bench/host byte source and the mipspipe IMEM write port and stall input.

---
 rtl/mips_loader_pkg.sv | 17 +
 rtl/mips_loader_pack.sv | 44 ++++
 rtl/mips_prog_loader.sv | 104 ++++++++++
 tb/tb_mips_prog_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/mips_loader_pack.sv
// Byte-to-word assembler: shifts bytes in MSB first and pulses word_valid
// for one cycle with the completed word.
module mips_loader_pack
  import mips_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  assign word_done = byte_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // word_out only changes on completion so the IMEM data bus holds between strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word_out   <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
        shift    <= '0;
      end else if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[15:0], byte_in};
        if (word_done) begin
          word_out   <= {shift, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into IMEM and
// holds the CPU until the image is loaded and verified.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int IMEM_AW = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam logic [CNT_W:0] CAP = {{CNT_W{1'b0}}, 1'b1} << IMEM_AW;

  state_t           state, state_nx;
  logic             xfer;
  logic             start_load;
  logic             word_done;
  logic             last_word;
  logic [7:0]       cnt_hi;
  logic [7:0]       acc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W:0]   n_full;

  // Outputs are decoded from the state register only, never from in_valid
  assign in_ready = state inside {HDR_HI, HDR_LO, PAYLOAD, CHECK};
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

  assign xfer       = in_valid && in_ready;
  assign start_load = start && (state inside {IDLE, DONE, ERR});
  assign n_full     = {1'b0, cnt_hi, in_data};
  assign last_word  = word_done && ((word_idx + CNT_W'(1)) == count);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = HDR_HI;
      HDR_HI:  if (xfer) state_nx = HDR_LO;
      HDR_LO:
        if (xfer) begin
          if (n_full > CAP)      state_nx = ERR;
          else if (n_full == '0) state_nx = CHECK;
          else                   state_nx = PAYLOAD;
        end
      PAYLOAD: if (last_word) state_nx = CHECK;
      CHECK:   if (xfer) state_nx = (in_data == acc) ? DONE : ERR;
      DONE:    if (start) state_nx = HDR_HI;
      ERR:     if (start) state_nx = HDR_HI;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      cnt_hi    <= '0;
      count     <= '0;
      word_idx  <= '0;
      imem_addr <= '0;
    end else if (start_load) begin
      acc      <= '0;
      word_idx <= '0;
    end else begin
      if (xfer && state != CHECK) acc <= acc ^ in_data;
      if (xfer && state == HDR_HI) cnt_hi <= in_data;
      if (xfer && state == HDR_LO) count <= {cnt_hi, in_data};
      // address registers alongside the assembled word, so both appear with imem_we
      if (word_done) begin
        imem_addr <= word_idx[IMEM_AW-1:0];
        word_idx  <= word_idx + CNT_W'(1);
      end
    end
  end

  mips_loader_pack u_pack (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_load),
    .byte_en    (xfer && state == PAYLOAD),
    .byte_in    (in_data),
    .word_done  (word_done),
    .word_valid (imem_we),
    .word_out   (imem_wdata)
  );

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader with a stream-level reference model.
module tb_mips_prog_loader;

  localparam int IMEM_AW = 10;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;

  mips_prog_loader #(.IMEM_AW(IMEM_AW), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_words[$];
  int          xcyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  // Reference stream: 16-bit count, big-endian words, XOR of all prior bytes.
  function automatic void make_stream(input int unsigned n);
    logic [7:0] x;
    logic [31:0] w;
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    foreach (exp_words[k]) begin
      w = exp_words[k];
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
    x = 8'h00;
    foreach (stream[k]) x = x ^ stream[k];
    stream.push_back(x);
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic drive(input int nbytes, input int gap_pct);
    int sent = 0;
    int budget = 0;
    xcyc.delete();
    while (sent < nbytes && budget < 4000) begin
      @(negedge clock);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? stream[sent] : 8'($urandom);
      if (in_valid && in_ready) begin
        xcyc.push_back(cyc);
        sent++;
      end
      budget++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    total++;
    if (sent < nbytes) begin
      bad++;
      $display("FAIL drive_timeout sent=%0d required=%0d", sent, nbytes);
    end
  endtask

  task automatic test_reset();
    do_reset();
    clear_log();
    in_valid = 1'b1; in_data = 8'hA5;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle rdy/hold/done/err=%b%b%b%b required=0100",
                 in_ready, cpu_hold, done, error);
      end
    end
    in_valid = 1'b0;
    total++;
    if (wr_addr.size() !== 0 || imem_addr !== '0 || imem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_outputs writes=%0d addr=%0h wdata=%h required 0/0/0",
               wr_addr.size(), imem_addr, imem_wdata);
    end
  endtask

  task automatic test_one_word();
    exp_words = '{32'h20010005};
    make_stream(1);
    total++;
    if (stream[6] !== 8'h25) begin
      bad++;
      $display("FAIL model_checksum got=%h required=25", stream[6]);
    end
    clear_log();
    pulse_start();
    drive(7, 0);
    repeat (2) @(negedge clock);
    total++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 32'h20010005 ||
        wr_cyc[0] !== xcyc[5] + 1) begin
      bad++;
      $display("FAIL one_word_write n=%0d addr=%0d data=%h required 1 write 0/20010005",
               wr_addr.size(), wr_addr.size() ? wr_addr[0] : -1,
               wr_data.size() ? wr_data[0] : 32'h0);
    end
    total++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL one_word_status done/hold/err/rdy=%b%b%b%b required=1000",
               done, cpu_hold, error, in_ready);
    end
  endtask

  task automatic test_two_words_gaps();
    exp_words = '{32'h00221820, 32'hAC030004};
    make_stream(2);
    total++;
    if (stream[10] !== 8'hB3) begin
      bad++;
      $display("FAIL model_checksum2 got=%h required=b3", stream[10]);
    end
    clear_log();
    pulse_start();
    drive(11, 50);
    repeat (2) @(negedge clock);
    total++;
    if (wr_addr.size() !== 2) begin
      bad++;
      $display("FAIL two_words_count got=%0d required=2", wr_addr.size());
    end
    for (int unsigned k = 0; k < 2 && k < wr_addr.size(); k++) begin
      total++;
      if (wr_addr[k] !== int'(k) || wr_data[k] !== exp_words[k] ||
          wr_cyc[k] !== xcyc[2 + 4*k + 3] + 1) begin
        bad++;
        $display("FAIL two_words_w%0d addr=%0d data=%h cyc=%0d required %0d/%h/%0d",
                 k, wr_addr[k], wr_data[k], wr_cyc[k], k, exp_words[k], xcyc[2+4*k+3]+1);
      end
    end
    total++;
    if (done !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL two_words_done done/err=%b%b required=10", done, error);
    end
  endtask

  task automatic test_bad_checksum();
    exp_words = '{32'h20010005};
    make_stream(1);
    stream[6] = 8'h24;
    clear_log();
    pulse_start();
    drive(7, 20);
    repeat (2) @(negedge clock);
    total++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 32'h20010005) begin
      bad++;
      $display("FAIL badsum_write n=%0d required 1 write of 20010005", wr_addr.size());
    end
    total++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL badsum_status err/done/hold=%b%b%b required=101", error, done, cpu_hold);
    end
    make_stream(1);
    clear_log();
    pulse_start();
    drive(7, 20);
    repeat (2) @(negedge clock);
    total++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || wr_addr.size() !== 1) begin
      bad++;
      $display("FAIL badsum_retry done/err/hold=%b%b%b writes=%0d required=100 writes=1",
               done, error, cpu_hold, wr_addr.size());
    end
  endtask

  task automatic test_oversize_zero();
    exp_words.delete();
    make_stream(32'h0401);
    clear_log();
    pulse_start();
    drive(2, 0);
    @(negedge clock);
    total++;
    if (error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || wr_addr.size() !== 0) begin
      bad++;
      $display("FAIL oversize err/done/rdy=%b%b%b writes=%0d required=100 writes=0",
               error, done, in_ready, wr_addr.size());
    end
    make_stream(0);
    total++;
    if (stream.size() !== 3 || stream[2] !== 8'h00) begin
      bad++;
      $display("FAIL model_zero size=%0d required=3", stream.size());
    end
    clear_log();
    pulse_start();
    drive(3, 30);
    repeat (2) @(negedge clock);
    total++;
    if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() !== 0) begin
      bad++;
      $display("FAIL zero_count done/err=%b%b writes=%0d required=10 writes=0",
               done, error, wr_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_words = '{32'h8C220004, 32'h00000000, 32'h1000FFFF};
    make_stream(3);
    clear_log();
    pulse_start();
    drive(4, 0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    total++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 ||
        wr_addr.size() !== 0) begin
      bad++;
      $display("FAIL reset_mid rdy/hold/done/err=%b%b%b%b writes=%0d required=0100 writes=0",
               in_ready, cpu_hold, done, error, wr_addr.size());
    end
    clear_log();
    pulse_start();
    drive(stream.size(), 25);
    repeat (2) @(negedge clock);
    total++;
    if (done !== 1'b1 || wr_addr.size() !== 3 || wr_addr[0] !== 0 || wr_data[2] !== 32'h1000FFFF) begin
      bad++;
      $display("FAIL reset_mid_reload done=%b writes=%0d required done=1 writes=3 from addr 0",
               done, wr_addr.size());
    end
  endtask

  task automatic test_random(input int iters, input int max_gap);
    for (int it = 0; it < iters; it++) begin
      int unsigned n = $urandom_range(1, 8);
      bit corrupt = ($urandom_range(3) == 0);
      exp_words.delete();
      for (int unsigned k = 0; k < n; k++) exp_words.push_back($urandom);
      make_stream(n);
      if (corrupt) stream[stream.size()-1] = stream[stream.size()-1] ^ 8'h5A;
      clear_log();
      pulse_start();
      drive(stream.size(), max_gap == 0 ? 0 : int'($urandom_range(max_gap)));
      repeat (2) @(negedge clock);
      total++;
      if (wr_addr.size() !== int'(n)) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d required=%0d", it, wr_addr.size(), n);
      end
      for (int unsigned k = 0; k < n && k < wr_addr.size(); k++) begin
        total++;
        if (wr_addr[k] !== int'(k) || wr_data[k] !== exp_words[k] ||
            wr_cyc[k] !== xcyc[2 + 4*k + 3] + 1) begin
          bad++;
          $display("FAIL rand%0d_w%0d addr=%0d data=%h cyc=%0d required %0d/%h/%0d",
                   it, k, wr_addr[k], wr_data[k], wr_cyc[k], k, exp_words[k], xcyc[2+4*k+3]+1);
        end
      end
      total++;
      if (done !== !corrupt || error !== corrupt || cpu_hold !== corrupt) begin
        bad++;
        $display("FAIL rand%0d_status done/err/hold=%b%b%b required=%b%b%b",
                 it, done, error, cpu_hold, !corrupt, corrupt, corrupt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_one_word();
    test_two_words_gaps();
    test_bad_checksum();
    test_oversize_zero();
    test_reset_mid();
    test_random(4, 0);   // back-to-back words, no bubbles
    test_random(8, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
